// File: rtl/memory_arbiter.sv
// Shares one single-port memory between instruction fetch (F) and load/store (D).
// Grants are held for a whole burst, alternate on ties, and completed transfers are counted per port.
module memory_arbiter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            fetchAddress,
    input  logic                   fetchLoad,
    output logic [31:0]            fetchData,
    output logic                   fetchReady,
    input  logic [31:0]            dataAddress,
    input  logic                   dataLoad,
    input  logic                   dataStore,
    input  logic [31:0]            dataWriteData,
    output logic [31:0]            dataData,
    output logic                   dataReady,
    output logic [31:0]            memAddress,
    output logic                   memLoad,
    output logic                   memStore,
    output logic [31:0]            memWriteData,
    input  logic [31:0]            memData,
    input  logic                   memReady,
    output logic [COUNT_WIDTH-1:0] fetchCount,
    output logic [COUNT_WIDTH-1:0] dataCount
);
    // state  | meaning
    // IDLE   | no grant; a non-requesting port sees memReady as its ready
    // SETTLE | device driven from the granted port for one cycle, readies low
    // ACTIVE | granted port passes straight through until its request drops

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    state_t state, state_next;
    logic   grant, grant_next;
    logic   last_grant, last_grant_next;
    logic   req_f, req_d, req_granted;
    logic   inc_fetch, inc_data;
    logic [COUNT_WIDTH-1:0] fetch_count_q, data_count_q;

    assign req_f       = fetchLoad;
    assign req_d       = dataLoad | dataStore;
    assign req_granted = (grant == PORT_D) ? req_d : req_f;

    assign fetchData  = memData;
    assign dataData   = memData;
    assign fetchCount = fetch_count_q;
    assign dataCount  = data_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= PORT_F;
            last_grant <= PORT_D;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q <= '0;
            data_count_q  <= '0;
        end else begin
            if (inc_fetch && (fetch_count_q != COUNT_MAX)) begin
                fetch_count_q <= fetch_count_q + 1'b1;
            end
            if (inc_data && (data_count_q != COUNT_MAX)) begin
                data_count_q <= data_count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        memAddress      = fetchAddress;
        memWriteData    = dataWriteData;
        memLoad         = 1'b0;
        memStore        = 1'b0;
        fetchReady      = 1'b0;
        dataReady       = 1'b0;
        inc_fetch       = 1'b0;
        inc_data        = 1'b0;

        // Once granted, the device follows the owner; a store wins over a simultaneous load.
        if (state != IDLE) begin
            if (grant == PORT_D) begin
                memAddress = dataAddress;
                memStore   = dataStore;
                memLoad    = dataLoad & ~dataStore;
            end else begin
                memAddress = fetchAddress;
                memLoad    = fetchLoad;
            end
        end

        unique case (state)
            IDLE: begin
                fetchReady = memReady & ~req_f;
                dataReady  = memReady & ~req_d;
                if (memReady && (req_f || req_d)) begin
                    if (req_f && req_d) begin
                        grant_next = ~last_grant;
                    end else begin
                        grant_next = req_d ? PORT_D : PORT_F;
                    end
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                state_next = req_granted ? ACTIVE : IDLE;
            end
            ACTIVE: begin
                if (grant == PORT_D) begin
                    dataReady = memReady;
                    inc_data  = memReady & req_d;
                end else begin
                    fetchReady = memReady;
                    inc_fetch  = memReady & req_f;
                end
                if (!req_granted) begin
                    last_grant_next = grant;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Keep the device and both requesters quiet while reset is held.
        if (reset) begin
            memLoad    = 1'b0;
            memStore   = 1'b0;
            fetchReady = 1'b0;
            dataReady  = 1'b0;
        end
    end
endmodule
